layer_param_loader: RTL and testbench

//   Sequences one weight or bias load per layer step. Takes the {firstaddr, lastaddr,
//   re_weights, re_bias} range produced by the step address map and streams every word
//   in [firstaddr, lastaddr) from the weight/bias memory into the compute-side buffer.

---
 rtl/layer_param_loader.sv | 136 +++++++++++++
 tb/tb_layer_param_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/layer_param_loader.sv
// Streams one parameter range [firstaddr, lastaddr) from weight or bias memory
// into the compute-side buffer, one read per cycle, with a fixed-latency valid pipe.
module layer_param_loader #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned BUF_AW = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] firstaddr,
   input  logic [ADDR_W-1:0] lastaddr,
   input  logic              re_weights,
   input  logic              re_bias,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re_w,
   output logic              mem_re_b,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              buf_we_w,
   output logic              buf_we_b,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] last_idx;
   logic [LAT_W-1:0]  drain_cnt;
   logic [RD_LAT-1:0] pipe_w;
   logic [RD_LAT-1:0] pipe_b;
   logic [BUF_AW-1:0] pipe_idx [RD_LAT];
   logic [ADDR_W-1:0] n_words;

   assign n_words = lastaddr - firstaddr;

   // Pipe tail marks the cycle the memory returns data for the tagged index
   assign buf_we_w = pipe_w[RD_LAT-1];
   assign buf_we_b = pipe_b[RD_LAT-1];
   assign buf_addr = pipe_idx[RD_LAT-1];
   assign buf_data = (pipe_w[RD_LAT-1] || pipe_b[RD_LAT-1]) ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         last_idx  <= '0;
         drain_cnt <= '0;
         mem_addr  <= '0;
         mem_re_w  <= 1'b0;
         mem_re_b  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         pipe_w    <= '0;
         pipe_b    <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) pipe_idx[i] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         // Tag each issued read with its target and range index
         for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
            pipe_w[i]   <= pipe_w[i-1];
            pipe_b[i]   <= pipe_b[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
         end
         pipe_w[0]   <= mem_re_w;
         pipe_b[0]   <= mem_re_b;
         pipe_idx[0] <= BUF_AW'(idx);

         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (!re_weights && !re_bias) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (lastaddr <= firstaddr) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= ISSUE;
                     mem_addr <= firstaddr;
                     mem_re_w <= re_weights;
                     mem_re_b <= !re_weights;
                     idx      <= '0;
                     last_idx <= n_words - ADDR_W'(1);
                  end
               end
            end
            ISSUE: begin
               if (idx == last_idx) begin
                  state     <= DRAIN;
                  mem_re_w  <= 1'b0;
                  mem_re_b  <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  idx      <= idx + ADDR_W'(1);
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == LAT_W'(RD_LAT - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + LAT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed bench for layer_param_loader with a 2-cycle-latency memory model.
module tb_layer_param_loader;

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned BUF_AW = 16;
   localparam int unsigned RD_LAT = 2;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] firstaddr;
   logic [ADDR_W-1:0] lastaddr;
   logic              re_weights;
   logic              re_bias;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re_w;
   logic              mem_re_b;
   logic [DATA_W-1:0] mem_rdata;
   logic              buf_we_w;
   logic              buf_we_b;
   logic [BUF_AW-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_err    = 0;

   layer_param_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_AW(BUF_AW), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .firstaddr(firstaddr), .lastaddr(lastaddr),
      .re_weights(re_weights), .re_bias(re_bias),
      .mem_addr(mem_addr), .mem_re_w(mem_re_w), .mem_re_b(mem_re_b),
      .mem_rdata(mem_rdata),
      .buf_we_w(buf_we_w), .buf_we_b(buf_we_b),
      .buf_addr(buf_addr), .buf_data(buf_data),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) ^ 16'hA5C3;
   endfunction

   // Memory model: data appears RD_LAT cycles after the address cycle
   logic [1:0]        rv;
   logic [ADDR_W-1:0] ra0, ra1;
   always @(posedge clk) begin
      rv  <= {rv[0], mem_re_w | mem_re_b};
      ra0 <= mem_addr;
      ra1 <= ra0;
   end
   assign mem_rdata = rv[1] ? mem_word(ra1) : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives start in the current cycle, follows the load to done, ends in the cycle after done
   task automatic run_load(input string tag, input logic [ADDR_W-1:0] fa, input logic [ADDR_W-1:0] la,
                           input logic rw, input logic rb, input bit mid_start);
      int   cyc, reads, writes, bad, done_cyc, n;
      logic err_seen, valid, tw;
      valid    = (rw || rb) && (la > fa);
      n        = valid ? int'(la - fa) : 0;
      tw       = rw;
      reads    = 0;
      writes   = 0;
      bad      = 0;
      done_cyc = -1;
      err_seen = 1'b0;
      firstaddr  = fa;
      lastaddr   = la;
      re_weights = rw;
      re_bias    = rb;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc <= n + 10) begin
         if (mem_re_w || mem_re_b) begin
            if ((tw && mem_re_b) || (!tw && mem_re_w)) bad++;
            chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(fa + ADDR_W'(reads)));
            reads++;
         end
         if (buf_we_w || buf_we_b) begin
            if ((tw && buf_we_b) || (!tw && buf_we_w)) bad++;
            chk({tag, "_buf_addr"}, 32'(buf_addr), 32'(BUF_AW'(writes)));
            chk({tag, "_buf_data"}, 32'(buf_data), 32'(mem_word(fa + ADDR_W'(writes))));
            writes++;
         end
         if (!busy) bad++;
         if (done) begin
            done_cyc = cyc;
            err_seen = err;
            break;
         end
         if (mid_start && cyc == 20) begin
            start      = 1'b1;
            firstaddr  = 18'd0;
            lastaddr   = 18'd5;
            re_weights = 1'b0;
            re_bias    = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, 32'(done_cyc), valid ? 32'(n + int'(RD_LAT) + 1) : 32'd1);
      chk({tag, "_reads"}, 32'(reads), 32'(n));
      chk({tag, "_writes"}, 32'(writes), 32'(n));
      chk({tag, "_err"}, 32'(err_seen), 32'(!(rw || rb)));
      chk({tag, "_bad_strobes"}, 32'(bad), 32'd0);
      @(negedge clk);
      chk({tag, "_idle_after"}, {29'd0, busy, done, err}, 32'd0);
   endtask

   initial begin
      int cyc, stray;
      rst_n      = 1'b0;
      start      = 1'b0;
      firstaddr  = '0;
      lastaddr   = '0;
      re_weights = 1'b0;
      re_bias    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_mem", {13'd0, mem_addr, mem_re_w, mem_re_b}, 32'd0);
      chk("reset_buf", {14'd0, buf_we_w, buf_we_b, buf_addr}, 32'd0);
      chk("reset_data", 32'(buf_data), 32'd0);
      chk("reset_status", {29'd0, busy, done, err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_load("t1_weights", 18'd0, 18'd216, 1'b1, 1'b0, 1'b0);
      run_load("t2_bias", 18'd8, 18'd16, 1'b0, 1'b1, 1'b0);
      run_load("t3_empty", 18'd500, 18'd500, 1'b1, 1'b0, 1'b0);
      run_load("t3_notarget", 18'd10, 18'd20, 1'b0, 1'b0, 1'b0);
      run_load("t4_both_sel", 18'd72, 18'd200, 1'b1, 1'b1, 1'b1);

      // Reset in the middle of a 216-word load
      firstaddr  = 18'd0;
      lastaddr   = 18'd216;
      re_weights = 1'b1;
      re_bias    = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_mem", {13'd0, mem_addr, mem_re_w, mem_re_b}, 32'd0);
      chk("t5_rst_buf", {14'd0, buf_we_w, buf_we_b, buf_addr}, 32'd0);
      chk("t5_rst_data", 32'(buf_data), 32'd0);
      chk("t5_rst_status", {29'd0, busy, done, err}, 32'd0);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mem_re_w || mem_re_b || buf_we_w || buf_we_b || busy || done || err) stray++;
      end
      chk("t5_no_activity", 32'(stray), 32'd0);

      run_load("t6_first", 18'd0, 18'd8, 1'b1, 1'b0, 1'b0);
      run_load("t6_b2b", 18'd35808, 18'd68576, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
